pitch_engine: RTL and testbench

- Parametrised successor to the single-target pitch core.
- Reads a PCM sample block from SDRAM through the shared read/write strobe-and-finished handshake.
- Resamples it by an integer factor: speed-up decimates, slow-down repeats or interpolates.
- Writes the result to up to N_DST target buffers.
- Sits between the top-level controller and the SDRAM arbiter port.

---
 rtl/pitch_pkg.sv | 40 ++++
 rtl/pitch_interp.sv | 25 ++
 rtl/pitch_engine.sv | 244 ++++++++++++++++++++++++
 tb/tb_pitch_engine.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pitch_pkg.sv
// pitch_pkg: shared types, limits and speed decoding for the pitch engine.
// Latency: n/a (declarations and pure functions only).
// Backpressure: n/a.
package pitch_pkg;

  // Control states of the engine
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_WR   = 3'd2,
    ST_GAP  = 3'd3,
    ST_DONE = 3'd4
  } pitch_state_t;

  // Resampling direction
  typedef enum logic {
    PITCH_FAST = 1'b0,
    PITCH_SLOW = 1'b1
  } pitch_mode_t;

  localparam int MAX_SPEED = 15;
  localparam int SPEED_W   = $clog2(MAX_SPEED + 1);

  // Speed codes 0 and 1 both mean a plain copy
  function automatic logic [SPEED_W-1:0] speed_norm(input logic [SPEED_W-1:0] code);
    if (code == '0) return SPEED_W'(1);
    return code;
  endfunction

  // log2 of the factor for the interpolating factors 2, 4 and 8; 0 means repeat only
  function automatic logic [1:0] speed_to_shift(input logic [SPEED_W-1:0] s);
    case (s)
      SPEED_W'(2): return 2'd1;
      SPEED_W'(4): return 2'd2;
      SPEED_W'(8): return 2'd3;
      default:     return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pitch_interp.sv
// pitch_interp: linear interpolation point y = x0 + ((x1 - x0) * r) >>> shift (used with PITCH_INTERP_EN).
// Latency: combinational.
// Backpressure: none; the caller holds operands stable while the write is outstanding.
module pitch_interp #(
  parameter int DATA_W = 16
) (
  input  logic signed [DATA_W-1:0] x0,
  input  logic signed [DATA_W-1:0] x1,
  input  logic        [2:0]        r,
  input  logic        [1:0]        shift,
  output logic signed [DATA_W-1:0] y
);

  // One extra bit keeps the difference exact; three more cover r up to 7
  logic signed [DATA_W:0]   delta;
  logic signed [DATA_W+3:0] prod;
  logic signed [DATA_W+3:0] scaled;

  assign delta  = {x1[DATA_W-1], x1} - {x0[DATA_W-1], x0};
  assign prod   = (DATA_W+4)'(delta) * (DATA_W+4)'($signed({1'b0, r}));
  // Arithmetic shift rounds toward minus infinity, keeping the result between x0 and x1
  assign scaled = prod >>> shift;
  assign y      = DATA_W'(scaled + (DATA_W+4)'(x0));

endmodule

// File: rtl/pitch_engine.sv
// pitch_engine: reads a PCM block from SDRAM, resamples it by integer factor S and writes it to N_DST targets; PITCH_INTERP_EN adds interpolated slow-down.
// Latency: one cycle from start to the first gap, then 1 + arbiter wait + 1 gap cycle per access; done follows the last gap.
// Backpressure: each strobe is held with stable address/data until its finished pulse; one idle cycle separates accesses.
module pitch_engine
  import pitch_pkg::*;
#(
  parameter int ADDR_W = 23,
  parameter int DATA_W = 16,
  parameter int N_DST  = 2
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         pitch_start,
  input  logic [ADDR_W-1:0]            pitch_src,
  input  logic [N_DST-1:0][ADDR_W-1:0] pitch_dst,
  input  logic [ADDR_W-1:0]            pitch_len,
  input  logic                         pitch_mode,
  input  logic [SPEED_W-1:0]           pitch_speed,
  output logic                         pitch_busy,
  output logic                         pitch_done,
  output logic [ADDR_W-1:0]            pitch_out_len,
  output logic                         pitch_read,
  output logic [ADDR_W-1:0]            pitch_addr,
  input  logic [DATA_W-1:0]            pitch_readdata,
  input  logic                         pitch_read_finished,
  output logic                         pitch_write,
  output logic [DATA_W-1:0]            pitch_writedata,
  input  logic                         pitch_write_finished
);

  localparam int D_W = (N_DST > 1) ? $clog2(N_DST) : 1;

  pitch_state_t state_q, state_d;

  // Job parameters captured at start
  logic [ADDR_W-1:0]            src_q;
  logic [ADDR_W-1:0]            len_q;
  logic [N_DST-1:0][ADDR_W-1:0] dst_q;
  pitch_mode_t                  mode_q;
  logic [SPEED_W-1:0]           s_q;
  logic                         interp_q;

  // Progress: source index, output index, repetition, target selector
  logic [ADDR_W:0]              i_q;
  logic [ADDR_W-1:0]            o_q;
  logic [SPEED_W-1:0]           r_q;
  logic [D_W-1:0]               d_q;
  logic                         need_rd_q;
  logic                         first_q;
  logic                         fin_q;
  logic signed [DATA_W-1:0]     x0_q;

  // Registered bus and status outputs
  logic                         read_q;
  logic                         write_q;
  logic [ADDR_W-1:0]            addr_q;
  logic [DATA_W-1:0]            wdata_q;
  logic                         busy_q;
  logic                         done_q;
  logic [ADDR_W-1:0]            out_len_q;

  logic [SPEED_W-1:0]           s_in;
  logic [SPEED_W-1:0]           reps;
  logic [SPEED_W-1:0]           step;
  logic [ADDR_W:0]              i_nxt;
  logic                         last_d;
  logic                         last_r;
  logic                         src_end;
  logic                         ahead_ok;
  logic [ADDR_W-1:0]            rd_addr;
  logic [ADDR_W-1:0]            wr_addr;
  logic [DATA_W-1:0]            wr_sample;
  logic signed [DATA_W-1:0]     ahead_x;

  assign s_in = speed_norm(pitch_speed);

  // Speed-up steps through the source by S with one output per read;
  // slow-down steps by one and emits S outputs per source sample.
  assign reps     = (mode_q == PITCH_SLOW) ? s_q : SPEED_W'(1);
  assign step     = (mode_q == PITCH_SLOW) ? SPEED_W'(1) : s_q;
  assign i_nxt    = i_q + (ADDR_W+1)'(step);
  assign last_d   = (d_q == D_W'(N_DST - 1));
  assign last_r   = (r_q == reps - SPEED_W'(1));
  assign src_end  = (i_nxt >= {1'b0, len_q});
  assign ahead_ok = ((i_nxt + (ADDR_W+1)'(1)) < {1'b0, len_q});

  // With interpolation the read after the first one fetches the look-ahead sample i+1
  assign rd_addr  = src_q + i_q[ADDR_W-1:0] + ADDR_W'(interp_q & ~first_q);
  assign wr_addr  = dst_q[d_q] + o_q;

`ifdef PITCH_INTERP_EN
  logic [1:0]               shift_q;
  logic signed [DATA_W-1:0] x1_q;
  logic signed [DATA_W-1:0] interp_y;

  // Interpolation operands: shift fixed per job, x1 holds the look-ahead sample
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      shift_q <= '0;
      x1_q    <= '0;
    end else begin
      if (state_q == ST_IDLE && pitch_start) shift_q <= speed_to_shift(s_in);
      if (state_q == ST_RD && pitch_read_finished && interp_q) x1_q <= pitch_readdata;
    end
  end

  pitch_interp #(
    .DATA_W (DATA_W)
  ) u_interp (
    .x0    (x0_q),
    .x1    (x1_q),
    .r     (r_q[2:0]),
    .shift (shift_q),
    .y     (interp_y)
  );

  assign wr_sample = interp_q ? interp_y : x0_q;
  // When no further sample is fetched x1 already equals the new x0, so the tail repeats
  assign ahead_x   = x1_q;
`else
  assign wr_sample = x0_q;
  assign ahead_x   = x0_q;
`endif

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state selection; GAP decides between read, write and completion
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (pitch_start)          state_d = ST_GAP;
      ST_RD:   if (pitch_read_finished)  state_d = ST_GAP;
      ST_WR:   if (pitch_write_finished) state_d = ST_GAP;
      ST_GAP: begin
        if (fin_q)          state_d = ST_DONE;
        else if (need_rd_q) state_d = ST_RD;
        else                state_d = ST_WR;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Capture on start, then advance target, repetition and source indices per completed access
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      src_q     <= '0;
      len_q     <= '0;
      dst_q     <= '0;
      mode_q    <= PITCH_FAST;
      s_q       <= SPEED_W'(1);
      interp_q  <= 1'b0;
      i_q       <= '0;
      o_q       <= '0;
      r_q       <= '0;
      d_q       <= '0;
      need_rd_q <= 1'b0;
      first_q   <= 1'b0;
      fin_q     <= 1'b0;
      x0_q      <= '0;
    end else begin
      if (state_q == ST_IDLE && pitch_start) begin
        src_q     <= pitch_src;
        dst_q     <= pitch_dst;
        len_q     <= pitch_len;
        mode_q    <= pitch_mode_t'(pitch_mode);
        s_q       <= s_in;
`ifdef PITCH_INTERP_EN
        interp_q  <= pitch_mode && (speed_to_shift(s_in) != 2'd0);
`else
        interp_q  <= 1'b0;
`endif
        i_q       <= '0;
        o_q       <= '0;
        r_q       <= '0;
        d_q       <= '0;
        first_q   <= 1'b1;
        need_rd_q <= (pitch_len != '0);
        fin_q     <= (pitch_len == '0);
      end
      if (state_q == ST_RD && pitch_read_finished) begin
        first_q   <= 1'b0;
        if (!interp_q || first_q) x0_q <= pitch_readdata;
        // After the very first interpolating read, fetch the look-ahead before writing
        need_rd_q <= interp_q && first_q && (len_q != ADDR_W'(1));
      end
      if (state_q == ST_WR && pitch_write_finished) begin
        if (last_d) begin
          d_q <= '0;
          o_q <= o_q + ADDR_W'(1);
          if (last_r) begin
            r_q <= '0;
            i_q <= i_nxt;
            if (interp_q) x0_q <= ahead_x;
            if (src_end) fin_q     <= 1'b1;
            else         need_rd_q <= interp_q ? ahead_ok : 1'b1;
          end else begin
            r_q <= r_q + SPEED_W'(1);
          end
        end else begin
          d_q <= d_q + D_W'(1);
        end
      end
    end
  end

  // Registered strobes, address, write data and status; address/data load only on access entry
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      read_q    <= 1'b0;
      write_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      out_len_q <= '0;
    end else begin
      read_q  <= (state_d == ST_RD);
      write_q <= (state_d == ST_WR);
      busy_q  <= (state_d != ST_IDLE);
      done_q  <= (state_d == ST_DONE);
      if (state_q == ST_GAP && state_d == ST_RD) addr_q <= rd_addr;
      if (state_q == ST_GAP && state_d == ST_WR) begin
        addr_q  <= wr_addr;
        wdata_q <= wr_sample;
      end
      // The output index has counted every emitted sample by the time DONE is entered
      if (state_d == ST_DONE) out_len_q <= o_q;
    end
  end

  assign pitch_read      = read_q;
  assign pitch_write     = write_q;
  assign pitch_addr      = addr_q;
  assign pitch_writedata = wdata_q;
  assign pitch_busy      = busy_q;
  assign pitch_done      = done_q;
  assign pitch_out_len   = out_len_q;

endmodule

// File: tb/tb_pitch_engine.sv
// tb_pitch_engine: randomised and directed stimulus for pitch_engine against a sample-list reference model.
// Latency: SDRAM responder answers each strobe after a random 0-7 cycle wait.
// Backpressure: responder holds finished off until its wait expires; protocol monitor runs throughout.
module tb_pitch_engine;

  localparam int AW = 23;
  localparam int DW = 16;
  localparam int ND = 2;
  localparam logic [AW-1:0] AMASK = '1;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  logic                 clk;
  logic                 i_rst;
  logic                 pitch_start;
  logic [AW-1:0]        pitch_src;
  logic [ND-1:0][AW-1:0] pitch_dst;
  logic [AW-1:0]        pitch_len;
  logic                 pitch_mode;
  logic [3:0]           pitch_speed;
  logic                 pitch_busy;
  logic                 pitch_done;
  logic [AW-1:0]        pitch_out_len;
  logic                 pitch_read;
  logic [AW-1:0]        pitch_addr;
  logic [DW-1:0]        pitch_readdata;
  logic                 pitch_read_finished;
  logic                 pitch_write;
  logic [DW-1:0]        pitch_writedata;
  logic                 pitch_write_finished;

  pitch_engine #(.ADDR_W(AW), .DATA_W(DW), .N_DST(ND)) dut (
    .i_clk                (clk),
    .i_rst                (i_rst),
    .pitch_start          (pitch_start),
    .pitch_src            (pitch_src),
    .pitch_dst            (pitch_dst),
    .pitch_len            (pitch_len),
    .pitch_mode           (pitch_mode),
    .pitch_speed          (pitch_speed),
    .pitch_busy           (pitch_busy),
    .pitch_done           (pitch_done),
    .pitch_out_len        (pitch_out_len),
    .pitch_read           (pitch_read),
    .pitch_addr           (pitch_addr),
    .pitch_readdata       (pitch_readdata),
    .pitch_read_finished  (pitch_read_finished),
    .pitch_write          (pitch_write),
    .pitch_writedata      (pitch_writedata),
    .pitch_write_finished (pitch_write_finished)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [DW-1:0] mem [logic [AW-1:0]];
  wr_t           got_q[$];
  wr_t           exp_q[$];
  logic [AW-1:0] exp_len;
  int            exp_reads;
  int            nreads;
  int            done_cnt;
  int            lat_min;
  int            lat_max;
  int            n_overlap;
  int            n_unstable;
  int            n_nogap;
  int            n_chk;
  int            n_fail;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
    if (mem.exists(a)) return mem[a];
    return '0;
  endfunction

  // Reference: list of (address, data) writes in order, output length and read count
  task automatic model(input logic [AW-1:0] src, input logic [AW-1:0] d0, input logic [AW-1:0] d1,
                       input int len, input bit mode, input int speed);
    int s, o, x0, x1, v, num, q;
    bit interp;
    logic [AW-1:0] dsts[ND];
    exp_q.delete();
    s = (speed == 0) ? 1 : speed;
    dsts[0] = d0;
    dsts[1] = d1;
    interp = 1'b0;
`ifdef PITCH_INTERP_EN
    interp = mode && (s == 2 || s == 4 || s == 8);
`endif
    o = 0;
    if (!mode) begin
      for (int i = 0; i < len; i += s) begin
        for (int d = 0; d < ND; d++) exp_q.push_back(wr_t'{dsts[d] + AW'(o), mem_rd(src + AW'(i))});
        o++;
      end
      exp_reads = (len + s - 1) / s;
      exp_len   = AW'(o);
    end else begin
      for (int i = 0; i < len; i++) begin
        x0 = int'($signed(mem_rd(src + AW'(i))));
        x1 = (i + 1 < len) ? int'($signed(mem_rd(src + AW'(i + 1)))) : x0;
        for (int r = 0; r < s; r++) begin
          if (interp) begin
            num = (x1 - x0) * r;
            q = num / s;
            if ((num % s) != 0 && num < 0) q = q - 1;
            v = x0 + q;
          end else begin
            v = x0;
          end
          for (int d = 0; d < ND; d++) exp_q.push_back(wr_t'{dsts[d] + AW'(o + r), DW'(v)});
        end
        o += s;
      end
      exp_reads = len;
      exp_len   = AW'(len * s) & AMASK;
    end
  endtask

  // SDRAM arbiter model: random wait, one-cycle finished pulse, driven just after the falling edge
  initial begin : responder
    int  wait_c;
    bit  acked;
    pitch_read_finished  = 1'b0;
    pitch_write_finished = 1'b0;
    pitch_readdata       = '0;
    wait_c = 0;
    acked  = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      pitch_read_finished  = 1'b0;
      pitch_write_finished = 1'b0;
      if (!pitch_read && !pitch_write) begin
        acked  = 1'b0;
        wait_c = $urandom_range(lat_max, lat_min);
      end else if (!acked) begin
        if (wait_c == 0) begin
          acked = 1'b1;
          if (pitch_read) begin
            pitch_read_finished = 1'b1;
            pitch_readdata      = mem_rd(pitch_addr);
            nreads++;
          end else begin
            pitch_write_finished = 1'b1;
            got_q.push_back(wr_t'{pitch_addr, pitch_writedata});
          end
        end else begin
          wait_c--;
        end
      end
    end
  end

  // Protocol monitor: finished seen here is the value the DUT sampled at the preceding edge
  initial begin : monitor
    bit            p_rd, p_wr;
    logic [AW-1:0] p_addr;
    logic [DW-1:0] p_wdat;
    p_rd = 1'b0;
    p_wr = 1'b0;
    p_addr = '0;
    p_wdat = '0;
    forever begin
      @(negedge clk);
      if (pitch_done) done_cnt++;
      if (pitch_read && pitch_write) n_overlap++;
      if (p_rd && pitch_read && pitch_addr !== p_addr) n_unstable++;
      if (p_wr && pitch_write && (pitch_addr !== p_addr || pitch_writedata !== p_wdat)) n_unstable++;
      if (((p_rd && pitch_read_finished) || (p_wr && pitch_write_finished)) && (pitch_read || pitch_write))
        n_nogap++;
      p_rd   = pitch_read;
      p_wr   = pitch_write;
      p_addr = pitch_addr;
      p_wdat = pitch_writedata;
    end
  end

  task automatic start_pulse(input logic [AW-1:0] src, input logic [AW-1:0] d0, input logic [AW-1:0] d1,
                             input int len, input bit mode, input int speed);
    got_q.delete();
    nreads   = 0;
    done_cnt = 0;
    @(negedge clk);
    pitch_src   = src;
    pitch_dst   = {d1, d0};
    pitch_len   = AW'(len);
    pitch_mode  = mode;
    pitch_speed = 4'(speed);
    pitch_start = 1'b1;
    @(negedge clk);
    pitch_start = 1'b0;
    // Scramble the job inputs; the engine must have latched them already
    pitch_src   = AW'($urandom);
    pitch_dst   = {AW'($urandom), AW'($urandom)};
    pitch_len   = AW'($urandom_range(50, 0));
    pitch_mode  = ~mode;
    pitch_speed = 4'($urandom);
  endtask

  task automatic run_op(input logic [AW-1:0] src, input logic [AW-1:0] d0, input logic [AW-1:0] d1,
                        input int len, input bit mode, input int speed, input bit poke);
    int cyc;
    model(src, d0, d1, len, mode, speed);
    start_pulse(src, d0, d1, len, mode, speed);
    chk("busy_after_start", pitch_busy, 1);
    cyc = 0;
    while (done_cnt == 0 && cyc < 30000) begin
      @(negedge clk);
      cyc++;
      pitch_start = (poke && cyc == 3);
    end
    pitch_start = 1'b0;
    chk("done_timeout", (cyc < 30000), 1);
    repeat (4) @(negedge clk);
    chk("done_once", done_cnt, 1);
    chk("busy_idle", pitch_busy, 0);
    chk("out_len", pitch_out_len, exp_len);
    chk("reads", nreads, exp_reads);
    chk("wr_count", got_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++)
      chk("wr", {got_q[k].a, got_q[k].d}, {exp_q[k].a, exp_q[k].d});
  endtask

  initial begin : main
    int            cyc, len, spd;
    bit            mode;
    logic [AW-1:0] src;
    n_chk = 0; n_fail = 0;
    n_overlap = 0; n_unstable = 0; n_nogap = 0;
    nreads = 0; done_cnt = 0;
    lat_min = 0; lat_max = 7;
    i_rst = 1'b1;
    pitch_start = 1'b0;
    pitch_src = '0; pitch_dst = '0; pitch_len = '0; pitch_mode = 1'b0; pitch_speed = '0;
    repeat (3) @(negedge clk);
    chk("rst_read", pitch_read, 0);
    chk("rst_write", pitch_write, 0);
    chk("rst_addr", pitch_addr, 0);
    chk("rst_wdata", pitch_writedata, 0);
    chk("rst_busy", pitch_busy, 0);
    chk("rst_done", pitch_done, 0);
    chk("rst_out_len", pitch_out_len, 0);
    i_rst = 1'b0;

    // Speed-up by 2 over 0..4
    for (int k = 0; k < 5; k++) mem[AW'(32'h100 + k)] = DW'(k);
    run_op(AW'(32'h100), AW'(32'h1000), AW'(32'h2000), 5, 1'b0, 2, 1'b0);
    chk("tp_fast_len", pitch_out_len, 3);

    // Slow-down by 3 over {10, -4}
    mem[AW'(32'h200)] = 16'd10;
    mem[AW'(32'h201)] = 16'hFFFC;
    run_op(AW'(32'h200), AW'(32'h3000), AW'(32'h4000), 2, 1'b1, 3, 1'b0);
    chk("tp_slow_len", pitch_out_len, 6);

    // Slow-down by 4 over {0, 8, -8}
    mem[AW'(32'h300)] = 16'd0;
    mem[AW'(32'h301)] = 16'd8;
    mem[AW'(32'h302)] = 16'hFFF8;
    run_op(AW'(32'h300), AW'(32'h5000), AW'(32'h6000), 3, 1'b1, 4, 1'b0);

    // Plain copy with codes 1 and 0
    for (int k = 0; k < 16; k++) mem[AW'(32'h400 + k)] = DW'($urandom);
    run_op(AW'(32'h400), AW'(32'h7000), AW'(32'h8000), 16, 1'b0, 1, 1'b0);
    run_op(AW'(32'h400), AW'(32'h7100), AW'(32'h8100), 16, 1'b1, 0, 1'b0);

    // Zero length: no accesses, done two cycles after start
    start_pulse(AW'(32'h400), AW'(32'h9000), AW'(32'h9100), 0, 1'b0, 3);
    chk("len0_busy_c1", pitch_busy, 1);
    chk("len0_done_c1", pitch_done, 0);
    @(negedge clk);
    chk("len0_done_c2", pitch_done, 1);
    repeat (3) @(negedge clk);
    chk("len0_done_once", done_cnt, 1);
    chk("len0_reads", nreads, 0);
    chk("len0_writes", got_q.size(), 0);
    chk("len0_out_len", pitch_out_len, 0);

    // Start pulse while busy is ignored
    run_op(AW'(32'h200), AW'(32'hA000), AW'(32'hB000), 2, 1'b1, 3, 1'b1);

    // Random jobs, including address wrap near the top of memory
    for (int t = 0; t < 10; t++) begin
      src  = (t % 3 == 0) ? (AMASK - AW'($urandom_range(3, 0))) : AW'($urandom);
      len  = $urandom_range(8, 1);
      mode = 1'($urandom);
      spd  = $urandom_range(15, 0);
      for (int k = 0; k < len; k++) mem[src + AW'(k)] = DW'($urandom);
      run_op(src, AW'($urandom), AMASK - AW'($urandom_range(5, 0)), len, mode, spd, 1'b0);
    end

    // Reset while a write is outstanding
    lat_min = 3;
    start_pulse(AW'(32'h200), AW'(32'hC000), AW'(32'hD000), 2, 1'b1, 3);
    cyc = 0;
    while (!pitch_write && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
    chk("rst_mid_saw_write", pitch_write, 1);
    i_rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_write", pitch_write, 0);
    chk("rst_mid_read", pitch_read, 0);
    chk("rst_mid_busy", pitch_busy, 0);
    i_rst = 1'b0;
    lat_min = 0;
    run_op(AW'(32'h300), AW'(32'hE000), AW'(32'hF000), 3, 1'b1, 4, 1'b0);

    chk("no_overlap", n_overlap, 0);
    chk("addr_stable", n_unstable, 0);
    chk("idle_gap", n_nogap, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
